posit_fma_sched: RTL and testbench

//  Arbitrates NREQ requesters for one shared, multi-cycle posit FMA datapath (decode -> FMA arithmetic -> encode).

---
 rtl/posit_fma_pkg.sv | 20 ++
 rtl/posit_fma_sched_if.sv | 40 ++++
 rtl/posit_fma_arb.sv | 64 ++++++
 rtl/posit_fma_sched.sv | 125 ++++++++++++
 tb/tb_posit_fma_sched.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_fma_pkg.sv
// Shared types and constants for the posit FMA scheduler slice.
// Holds the FSM state encoding and the NaR pattern helper used by posit_fma_sched.
package posit_fma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } fma_sched_state_t;

  localparam int NREQ_DEFAULT = 4;
  localparam int ID_W         = $clog2(NREQ_DEFAULT);
  localparam int NAR_MAX_W    = 64;

  // NaR is the sign bit alone: 1 followed by n-1 zeros.
  function automatic logic [NAR_MAX_W-1:0] nar_const(input int n);
    return NAR_MAX_W'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/posit_fma_sched_if.sv
// Request, datapath and response signals of the posit FMA scheduler.
// master: the scheduler itself; slave: issue logic, datapath and response consumer.
interface posit_fma_sched_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*N-1:0] req_c;

  logic              dp_start;
  logic [N-1:0]      dp_a;
  logic [N-1:0]      dp_b;
  logic [N-1:0]      dp_c;
  logic [N-1:0]      dp_result;
  logic              dp_inf;
  logic              dp_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_nar;
  logic              busy;

  modport master (
    input  req_valid, req_a, req_b, req_c, dp_result, dp_inf, dp_zero, rsp_ready,
    output req_ready, dp_start, dp_a, dp_b, dp_c, rsp_valid, rsp_data, rsp_id, rsp_nar, busy
  );

  modport slave (
    output req_valid, req_a, req_b, req_c, dp_result, dp_inf, dp_zero, rsp_ready,
    input  req_ready, dp_start, dp_a, dp_b, dp_c, rsp_valid, rsp_data, rsp_id, rsp_nar, busy
  );

endinterface

// File: rtl/posit_fma_arb.sv
// Request arbiter for the posit FMA scheduler: fixed lowest-index priority by default,
// round-robin with a priority pointer when POSIT_FMA_RR_ARB_EN is defined.
module posit_fma_arb #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt
);

  logic found;

`ifdef POSIT_FMA_RR_ARB_EN
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  // Search starts at the pointer and wraps past NREQ-1 back to 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
        gnt[(int'(ptr_q) + i) % NREQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) ptr_d = IDW'((i + 1) % NREQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = clk ^ rst_n ^ adv;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/posit_fma_sched.sv
// Shares one multi-cycle posit FMA datapath (A*B+C) among NREQ requesters and returns
// tagged results. Define POSIT_FMA_RR_ARB_EN for round-robin instead of fixed priority.
module posit_fma_sched
  import posit_fma_pkg::*;
#(
  parameter int N    = 32,
  parameter int ES   = 2,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input logic               clk,
  input logic               rst_n,
  posit_fma_sched_if.master bus
);

  localparam int IDW   = $clog2(NREQ);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [N-1:0] NAR = N'(nar_const(N));

  fma_sched_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   g_idx;
  logic [N-1:0]     a_sel, b_sel, c_sel;
  logic             accept, any_nar;

  logic [N-1:0]     dp_a_q, dp_b_q, dp_c_q, rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             dp_start_q, rsp_nar_q;

  // A zero result is already all-zeros in rsp_data, so the zero flag carries no extra information.
  logic unused_zero;
  assign unused_zero = bus.dp_zero;

  posit_fma_arb #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .adv   (accept),
    .gnt   (gnt)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) g_idx = IDW'(i);
    end
  end

  assign a_sel   = bus.req_a[int'(g_idx)*N +: N];
  assign b_sel   = bus.req_b[int'(g_idx)*N +: N];
  assign c_sel   = bus.req_c[int'(g_idx)*N +: N];
  assign any_nar = (a_sel == NAR) || (b_sel == NAR) || (c_sel == NAR);
  assign accept  = (state_q == IDLE) && (|gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)          state_d = any_nar ? RESP : RUN;
      RUN:     if (cnt_q == '0)     state_d = RESP;
      RESP:    if (bus.rsp_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE) ? gnt : '0;
    bus.rsp_valid = (state_q == RESP);
    bus.busy      = (state_q != IDLE);
  end

  // Operands are captured once at the grant and held until the next grant, which keeps
  // them stable for the whole RUN window; the NaR short-circuit never starts the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dp_start_q <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      dp_c_q     <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_nar_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
      dp_start_q <= accept && !any_nar;
      if (accept) begin
        dp_a_q   <= a_sel;
        dp_b_q   <= b_sel;
        dp_c_q   <= c_sel;
        rsp_id_q <= g_idx;
        cnt_q    <= CNT_W'(LAT - 1);
        if (any_nar) begin
          rsp_data_q <= NAR;
          rsp_nar_q  <= 1'b1;
        end
      end else if (state_q == RUN) begin
        if (cnt_q == '0) begin
          rsp_data_q <= bus.dp_result;
          rsp_nar_q  <= bus.dp_inf;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign bus.dp_start = dp_start_q;
  assign bus.dp_a     = dp_a_q;
  assign bus.dp_b     = dp_b_q;
  assign bus.dp_c     = dp_c_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_id   = rsp_id_q;
  assign bus.rsp_nar  = rsp_nar_q;

endmodule

// File: tb/tb_posit_fma_sched.sv
// Directed bench for posit_fma_sched (N=32, LAT=3, NREQ=4) with a fixed-latency datapath stub.
// Expected grant orders follow POSIT_FMA_RR_ARB_EN when it is defined.
module tb_posit_fma_sched;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  posit_fma_sched_if #(.N(N), .NREQ(NREQ)) bus ();

  posit_fma_sched #(.N(N), .ES(2), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Datapath stub: result and flag are only meaningful in cycle LAT of an operation.
  logic [31:0] stub_val;
  logic        stub_inf;
  int          age_q;
  int          cur_age;
  assign cur_age = bus.dp_start ? 1 : age_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= 0;
    else        age_q <= bus.dp_start ? 2 : ((age_q != 0) ? age_q + 1 : 0);
  end
  assign bus.dp_result = (cur_age == LAT) ? stub_val : 32'hDEAD_BEEF;
  assign bus.dp_inf    = (cur_age == LAT) ? stub_inf : 1'b1;
  assign bus.dp_zero   = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus.req_a[i*N +: N] = a;
    bus.req_b[i*N +: N] = b;
    bus.req_c[i*N +: N] = c;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    stub_val      = 32'h0;
    stub_inf      = 1'b0;
    tick();
    tick();
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.dp_start !== 1'b0) begin fails++; $display("FAIL reset_dp_start got %b want 0", bus.dp_start); end
    tests++; if (bus.rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
    tests++; if (bus.rsp_id !== 2'd0 || bus.rsp_nar !== 1'b0) begin fails++; $display("FAIL reset_rsp_id_nar got %0d/%b want 0/0", bus.rsp_id, bus.rsp_nar); end
    tests++; if (bus.dp_a !== 32'h0 || bus.dp_b !== 32'h0 || bus.dp_c !== 32'h0) begin fails++; $display("FAIL reset_dp_operands got %h %h %h want 0", bus.dp_a, bus.dp_b, bus.dp_c); end
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    rst_n = 1'b1;
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    set_req(2, 32'h4000_0000, 32'h4800_0000, 32'h4000_0000);
    stub_val      = 32'h4C00_0000;
    stub_inf      = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_grant got %b want 0100", bus.req_ready); end
    tick();  // T+1
    bus.req_valid = '0;
    tests++; if (bus.dp_start !== 1'b1) begin fails++; $display("FAIL single_dp_start_t1 got %b want 1", bus.dp_start); end
    tests++; if (bus.dp_a !== 32'h4000_0000 || bus.dp_b !== 32'h4800_0000 || bus.dp_c !== 32'h4000_0000) begin
      fails++; $display("FAIL single_operands got %h %h %h want 40000000 48000000 40000000", bus.dp_a, bus.dp_b, bus.dp_c); end
    tests++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_t1_state got busy=%b valid=%b want 1/0", bus.busy, bus.rsp_valid); end
    tick();  // T+2
    tests++; if (bus.dp_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_t2 got start=%b valid=%b want 0/0", bus.dp_start, bus.rsp_valid); end
    tick();  // T+3
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_t3_valid got %b want 0", bus.rsp_valid); end
    tick();  // T+4
    tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL single_t4_valid got %b want 1", bus.rsp_valid); end
    tests++; if (bus.rsp_data !== 32'h4C00_0000) begin fails++; $display("FAIL single_rsp_data got %h want 4c000000", bus.rsp_data); end
    tests++; if (bus.rsp_id !== 2'd2 || bus.rsp_nar !== 1'b0) begin fails++; $display("FAIL single_rsp_id_nar got %0d/%b want 2/0", bus.rsp_id, bus.rsp_nar); end
    tick();  // T+5
    tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_back_idle got busy=%b valid=%b want 0/0", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_g [4];
    int k;
    int last_cyc;
`ifdef POSIT_FMA_RR_ARB_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001; exp_g[3] = 4'b0001;
`endif
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_req(0, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000);
    set_req(1, 32'h4800_0000, 32'h4000_0000, 32'h0000_0000);
    set_req(3, 32'h5000_0000, 32'h4000_0000, 32'h0000_0000);
    stub_val      = 32'h4000_0000;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1011;
    k        = 0;
    last_cyc = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      #1;
      if (bus.req_ready !== 4'b0000) begin
        tests++; if (bus.req_ready !== exp_g[k]) begin fails++; $display("FAIL arb_grant_%0d got %b want %b", k, bus.req_ready, exp_g[k]); end
        if (k > 0) begin
          tests++; if (cyc - last_cyc != LAT + 2) begin fails++; $display("FAIL arb_spacing_%0d got %0d want %0d", k, cyc - last_cyc, LAT + 2); end
        end
        last_cyc = cyc;
        k++;
      end
      tick();
    end
    tests++; if (k != 4) begin fails++; $display("FAIL arb_grant_count got %0d want 4", k); end
    bus.req_valid = '0;
    for (int w = 0; w < 20 && bus.busy; w++) tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL arb_drain got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_nar();
    set_req(3, 32'h4000_0000, 32'h8000_0000, 32'h4000_0000);
    stub_val      = 32'h1234_5678;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    tests++; if (bus.req_ready !== 4'b1000) begin fails++; $display("FAIL nar_grant got %b want 1000", bus.req_ready); end
    tick();  // T+1
    bus.req_valid = '0;
    tests++; if (bus.dp_start !== 1'b0) begin fails++; $display("FAIL nar_dp_start got %b want 0", bus.dp_start); end
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_nar !== 1'b1) begin fails++; $display("FAIL nar_valid_flag got %b/%b want 1/1", bus.rsp_valid, bus.rsp_nar); end
    tests++; if (bus.rsp_data !== 32'h8000_0000 || bus.rsp_id !== 2'd3) begin fails++; $display("FAIL nar_data_id got %h/%0d want 80000000/3", bus.rsp_data, bus.rsp_id); end
    tick();  // T+2
    tests++; if (bus.dp_start !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL nar_after got start=%b busy=%b want 0/0", bus.dp_start, bus.busy); end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_idle;
    int w;
`ifdef POSIT_FMA_RR_ARB_EN
    exp_idle = 4'b0010;
`else
    exp_idle = 4'b0001;
`endif
    set_req(0, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000);
    stub_val      = 32'h4000_0000;
    stub_inf      = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL bp_grant got %b want 0001", bus.req_ready); end
    tick();  // T+1
    bus.req_valid = 4'b1111;
    w = 0;
    while (w < 10 && !bus.rsp_valid) begin
      #1;
      tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_run_ready got %b want 0000", bus.req_ready); end
      tick();
      w++;
    end
    tests++; if (w != LAT) begin fails++; $display("FAIL bp_latency got %0d want %0d", w, LAT); end
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL bp_hold_%0d got valid=%b busy=%b want 1/1", i, bus.rsp_valid, bus.busy); end
      tests++; if (bus.rsp_data !== 32'h4000_0000 || bus.rsp_id !== 2'd0 || bus.rsp_nar !== 1'b0) begin
        fails++; $display("FAIL bp_rsp_%0d got %h/%0d/%b want 40000000/0/0", i, bus.rsp_data, bus.rsp_id, bus.rsp_nar); end
      tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_req_ready_%0d got %b want 0000", i, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_release_ready got %b want 0000", bus.req_ready); end
    tick();
    tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_idle got busy=%b valid=%b want 0/0", bus.busy, bus.rsp_valid); end
    tests++; if (bus.req_ready !== exp_idle) begin fails++; $display("FAIL bp_idle_grant got %b want %b", bus.req_ready, exp_idle); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    set_req(1, 32'h4800_0000, 32'h4800_0000, 32'h4000_0000);
    stub_val      = 32'h5000_0000;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL rmid_grant got %b want 0010", bus.req_ready); end
    tick();  // first RUN cycle
    bus.req_valid = '0;
    tick();  // second RUN cycle
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rmid_running got busy=%b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dp_start !== 1'b0) begin
      fails++; $display("FAIL rmid_immediate got valid=%b busy=%b start=%b want 0/0/0", bus.rsp_valid, bus.busy, bus.dp_start); end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid || bus.dp_start || bus.busy) seen = 1'b1;
      tick();
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rmid_no_response got activity=%b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_vals [3];
    logic [31:0] latched_a;
    int          acc_cyc [3];
    int          k;
    a_vals[0] = 32'h4000_0000;
    a_vals[1] = 32'h4800_0000;
    a_vals[2] = 32'h5000_0000;
    latched_a = 32'h0;
    set_req(1, a_vals[0], 32'h4000_0000, 32'h0000_0000);
    stub_val      = 32'h3C00_0000;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (k == 3 && !bus.busy) break;
      #1;
      if (bus.req_ready[1]) begin
        acc_cyc[k] = cyc;
        latched_a  = a_vals[k];
        k++;
        tick();
        if (k < 3) bus.req_a[1*N +: N] = a_vals[k];
        else       bus.req_valid = '0;
      end else begin
        if (bus.busy && !bus.rsp_valid) begin
          tests++; if (bus.dp_a !== latched_a) begin fails++; $display("FAIL b2b_dp_a_stable got %h want %h", bus.dp_a, latched_a); end
        end
        if (bus.rsp_valid) begin
          tests++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'h3C00_0000) begin fails++; $display("FAIL b2b_rsp got %0d/%h want 1/3c000000", bus.rsp_id, bus.rsp_data); end
        end
        tick();
      end
    end
    tests++; if (k != 3) begin fails++; $display("FAIL b2b_accept_count got %0d want 3", k); end
    if (k == 3) begin
      tests++; if (acc_cyc[1] - acc_cyc[0] != LAT + 2) begin fails++; $display("FAIL b2b_gap_0 got %0d want %0d", acc_cyc[1] - acc_cyc[0], LAT + 2); end
      tests++; if (acc_cyc[2] - acc_cyc[1] != LAT + 2) begin fails++; $display("FAIL b2b_gap_1 got %0d want %0d", acc_cyc[2] - acc_cyc[1], LAT + 2); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_nar();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
